// File: rtl/axi_wr_slave_mem.sv
// AXI4 write-path slave with a byte-strobed word memory, one transaction at a time (FIXED/INCR/WRAP).
// Optional define AXI_WR_SLAVE_WID_CHECK_EN: reject beats whose wid differs from the latched awid.
module axi_wr_slave_mem #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [ID_WIDTH-1:0]          awid,
  input  logic [ADDR_WIDTH-1:0]        awaddr,
  input  logic [7:0]                   awlen,
  input  logic [2:0]                   awsize,
  input  logic [1:0]                   awburst,
  input  logic                         awvalid,
  output logic                         awready,
  input  logic [ID_WIDTH-1:0]          wid,
  input  logic [DATA_WIDTH-1:0]        wdata,
  input  logic [DATA_WIDTH/8-1:0]      wstrb,
  input  logic                         wlast,
  input  logic                         wvalid,
  output logic                         wready,
  output logic [ID_WIDTH-1:0]          bid,
  output logic [1:0]                   bresp,
  output logic                         bvalid,
  input  logic                         bready,
  input  logic [$clog2(MEM_DEPTH)-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0]        dbg_rdata
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int OFF_W      = $clog2(STRB_WIDTH);
  localparam int IDX_W      = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] MEM_DEPTH_A = ADDR_WIDTH'(MEM_DEPTH);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_RESP} state_e;

  state_e                  state_q;
  logic                    awready_q, wready_q, bvalid_q;
  logic [ID_WIDTH-1:0]     bid_q, id_q;
  logic [1:0]              bresp_q, burst_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [7:0]              len_q, beat_cnt_q;
  logic [2:0]              size_q;
  logic                    err_q, lerr_q;

  logic [ADDR_WIDTH-1:0]   incr, wrap_mask, addr_d, word_idx;
  logic                    aw_err, in_range, beat, last_beat, wid_ok, beat_err, mem_we;

  logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

`ifdef AXI_WR_SLAVE_WID_CHECK_EN
  assign wid_ok = (wid == id_q);
`else
  logic unused_wid;
  assign unused_wid = ^wid;
  assign wid_ok     = 1'b1;
`endif

  // Errors detectable from the AW request alone; they also suppress every memory write.
  assign aw_err = (awsize > 3'(OFF_W)) || (awburst == 2'b11) ||
                  ((awburst == BURST_WRAP) && !(awlen inside {8'd1, 8'd3, 8'd7, 8'd15}));

  // NOTE: every variable assigned here gets a value on every path, so no latch is inferred.
  always_comb begin
    incr      = ADDR_WIDTH'(1) << size_q;
    wrap_mask = incr * (ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) - ADDR_WIDTH'(1);
    addr_d    = addr_q;
    case (burst_q)
      BURST_FIXED: addr_d = addr_q;
      BURST_INCR:  addr_d = (addr_q & ~(incr - ADDR_WIDTH'(1))) + incr;
      BURST_WRAP:  addr_d = (addr_q & ~wrap_mask) | ((addr_q + incr) & wrap_mask);
      default:     addr_d = addr_q;
    endcase
  end

  assign word_idx  = addr_q >> OFF_W;
  assign in_range  = (word_idx < MEM_DEPTH_A);
  assign beat      = (state_q == ST_DATA) && wvalid && wready_q;
  assign last_beat = (beat_cnt_q == len_q);
  assign beat_err  = !in_range || !wid_ok || (wlast != last_beat);
  assign mem_we    = beat && in_range && !lerr_q && wid_ok;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= ST_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bid_q      <= '0;
      bresp_q    <= RESP_OKAY;
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      burst_q    <= BURST_FIXED;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
      lerr_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (awvalid && awready_q) begin
            id_q       <= awid;
            addr_q     <= awaddr;
            len_q      <= awlen;
            size_q     <= awsize;
            burst_q    <= awburst;
            beat_cnt_q <= '0;
            err_q      <= aw_err;
            lerr_q     <= aw_err;
            awready_q  <= 1'b0;
            wready_q   <= 1'b1;
            state_q    <= ST_DATA;
          end else begin
            awready_q  <= 1'b1;
          end
        end
        ST_DATA: begin
          if (beat) begin
            addr_q     <= addr_d;
            beat_cnt_q <= beat_cnt_q + 8'd1;
            if (beat_err) err_q <= 1'b1;
            if (last_beat) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bid_q    <= id_q;
              bresp_q  <= (err_q || beat_err) ? RESP_SLVERR : RESP_OKAY;
              state_q  <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          if (bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            state_q   <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // NOTE: the memory array has no reset; contents survive aresetn and start undefined.
  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (wstrb[b]) mem[word_idx[IDX_W-1:0]][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign dbg_rdata = mem[dbg_addr];
  assign awready   = awready_q;
  assign wready    = wready_q;
  assign bvalid    = bvalid_q;
  assign bid       = bid_q;
  assign bresp     = bresp_q;

endmodule
